// File: rtl/ps2_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_tx_if -- command-side handshake of the PS/2 host transmitter.
//
//   wr_ps2        single-cycle request to send din (honoured only when idle)
//   din[7:0]      command byte, captured when wr_ps2 is accepted
//   tx_idle       transmitter idle and ready for a request
//   tx_done_tick  one-cycle pulse: byte sent and acknowledged by the device
//   tx_err_tick   one-cycle pulse: no acknowledge, or device clock timed out
//
// master: the user logic issuing commands. slave: the ps2_tx block.
// ---------------------------------------------------------------------------
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    modport master (
        output wr_ps2,
        output din,
        input  tx_idle,
        input  tx_done_tick,
        input  tx_err_tick
    );

    modport slave (
        input  wr_ps2,
        input  din,
        output tx_idle,
        output tx_done_tick,
        output tx_err_tick
    );
endinterface

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte to the keyboard: holds ps2c low for request-to-send,
// puts the start bit on ps2d, then shifts the byte out LSB-first followed by
// odd parity and the stop bit, one bit per device clock falling edge, and
// finally checks the device acknowledge. Both pins are open-drain: they are
// only ever pulled low or released. A receiver sharing the pins should ignore
// line activity while tx_idle is low.
//
// Ports:
//   clk     system clock (50 MHz nominal)
//   reset   asynchronous, active-high; releases both lines, returns to idle
//   bus     ps2_tx_if.slave handshake (wr_ps2, din, tx_idle, ticks)
//   ps2c    PS/2 clock pin, driven 0 or high-Z
//   ps2d    PS/2 data pin, driven 0 or high-Z
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles ps2c is held low for request-to-send
//   TIMEOUT_CYCLES  max clk cycles between device clock falls before abort
// ---------------------------------------------------------------------------
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic    clk,
    input  logic    reset,
    ps2_tx_if.slave bus,
    inout  tri      ps2c,
    inout  tri      ps2d
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    state_t           state;
    logic             c_sync1, c_sync2;
    logic             d_sync1, d_sync2;
    logic [7:0]       filt;
    logic             f_val;
    logic             f_next;
    logic             fall;
    logic [8:0]       sh;
    logic [3:0]       n;
    logic [CNT_W-1:0] cnt;
    logic             c_low;
    logic             d_low;
    logic             idle_q;
    logic             done_q;
    logic             err_q;

    // Open-drain pins: pull low or release, never drive high.
    assign ps2c = c_low ? 1'b0 : 1'bz;
    assign ps2d = d_low ? 1'b0 : 1'bz;

    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err_tick  = err_q;

    // -----------------------------------------------------------------------
    // Line conditioning: 2-flop synchronisers on both pins, and an 8-sample
    // filter on the clock so that short glitches never produce a fall.
    // Everything presets to 1 because an idle bus floats high.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync1 <= 1'b1;
            c_sync2 <= 1'b1;
            d_sync1 <= 1'b1;
            d_sync2 <= 1'b1;
            filt    <= 8'hFF;
            f_val   <= 1'b1;
        end else begin
            c_sync1 <= ps2c;
            c_sync2 <= c_sync1;
            d_sync1 <= ps2d;
            d_sync2 <= d_sync1;
            filt    <= {c_sync2, filt[7:1]};
            f_val   <= f_next;
        end
    end

    // NOTE: f_next gets a value on every path (default first), otherwise the
    // "hold" case would infer a latch.
    always_comb begin
        f_next = f_val;
        if (filt == 8'hFF)
            f_next = 1'b1;
        else if (filt == 8'h00)
            f_next = 1'b0;
    end

    assign fall = f_val & ~f_next;

    // -----------------------------------------------------------------------
    // Transfer FSM. One counter serves both the request-to-send inhibit (RTS)
    // and the inter-edge timeout (START..WAIT); the two uses never overlap.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            sh     <= '0;
            n      <= '0;
            cnt    <= '0;
            c_low  <= 1'b0;
            d_low  <= 1'b0;
            idle_q <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: ticks default low every cycle and are raised only on the
            // transition that produces them, so each lasts exactly one cycle.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                S_IDLE: begin
                    idle_q <= 1'b1;
                    // Gating on idle_q (not on the state) ignores a request
                    // arriving in the same cycle as a done/error tick.
                    if (bus.wr_ps2 && idle_q) begin
                        sh     <= {~^bus.din, bus.din};
                        n      <= '0;
                        cnt    <= '0;
                        c_low  <= 1'b1;
                        idle_q <= 1'b0;
                        state  <= S_RTS;
                    end
                end

                S_RTS: begin
                    if (cnt == RTS_LAST) begin
                        cnt   <= '0;
                        c_low <= 1'b0;
                        d_low <= 1'b1;  // start bit, same cycle the clock is released
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    // Device-clocked phase, supervised by the edge timeout.
                    if (fall)
                        cnt <= '0;
                    else
                        cnt <= cnt + 1'b1;

                    if (!fall && cnt == TMO_LAST) begin
                        c_low <= 1'b0;
                        d_low <= 1'b0;
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        case (state)
                            S_START: begin
                                if (fall) begin
                                    d_low <= ~sh[0];
                                    sh    <= {1'b0, sh[8:1]};
                                    n     <= 4'd1;
                                    state <= S_DATA;
                                end
                            end

                            S_DATA: begin
                                if (fall) begin
                                    n <= n + 1'b1;
                                    // Edge 10: all nine frame bits are out,
                                    // release the line for the stop bit.
                                    if (n == 4'd9) begin
                                        d_low <= 1'b0;
                                        state <= S_STOP;
                                    end else begin
                                        d_low <= ~sh[0];
                                        sh    <= {1'b0, sh[8:1]};
                                    end
                                end
                            end

                            S_STOP: begin
                                if (fall) begin
                                    if (!d_sync2) begin
                                        state <= S_WAIT;
                                    end else begin
                                        err_q <= 1'b1;
                                        state <= S_IDLE;
                                    end
                                end
                            end

                            S_WAIT: begin
                                if (c_sync2 && d_sync2) begin
                                    done_q <= 1'b1;
                                    state  <= S_IDLE;
                                end
                            end

                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx -- directed self-checking bench for ps2_tx.
//
// A behavioural keyboard drives the open-drain bus (pull-ups on both lines),
// generates device clocks and samples data on its rising edges. Expected
// frames are built from hand-computed parity constants.
// ---------------------------------------------------------------------------
module tb_ps2_tx;

    localparam int INHIBIT = 200;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 30;   // device clock half period, in clk cycles

    logic clk = 1'b0;
    logic reset;
    wire  ps2c;
    wire  ps2d;
    logic dev_c = 1'b0;   // device pulls ps2c low
    logic dev_d = 1'b0;   // device pulls ps2d low

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_tx_if bus ();

    ps2_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .ps2c (ps2c),
        .ps2d (ps2d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick monitor: counts ticks, pulse width and tx_idle relation.
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   err_cyc  = 0;
    int   wide_cnt = 0;
    int   idle_bad = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_done_tick) done_cnt <= done_cnt + 1;
        if (bus.tx_err_tick) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if ((prev_done && bus.tx_done_tick) || (prev_err && bus.tx_err_tick))
            wide_cnt <= wide_cnt + 1;
        if (((prev_done || prev_err) && !bus.tx_idle) ||
            ((bus.tx_done_tick || bus.tx_err_tick) && bus.tx_idle))
            idle_bad <= idle_bad + 1;
        prev_done <= bus.tx_done_tick;
        prev_err  <= bus.tx_err_tick;
    end

    int checks = 0;
    int errors = 0;
    int last_fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.din    = d;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
    endtask

    // Behavioural device: measures request-to-send, then clocks the frame.
    // bits[0] start, bits[8:1] data, bits[9] parity, bits[10] stop.
    task automatic device_frame(input logic ack, input int stop_after, input int poke_edge,
                                input int glitch_edge, input string tag, output logic [10:0] bits);
        int len;
        bits = '1;
        len  = 0;
        while (ps2c !== 1'b0 && len < 100) begin
            len++;
            @(negedge clk);
        end
        check({tag, "_rts_seen"}, 32'(ps2c), 32'd0);
        len = 0;
        while (ps2c === 1'b0 && len < 4 * INHIBIT) begin
            len++;
            @(negedge clk);
        end
        check({tag, "_rts_len"}, 32'(len), 32'(INHIBIT));
        bits[0] = ps2d;
        for (int k = 1; k <= stop_after; k++) begin
            if (k == 11 && ack) dev_d = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c         = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_c = 1'b0;
            if (k <= 10) bits[k] = ps2d;
            if (k == poke_edge) begin
                bus.din    = 8'hAA;
                bus.wr_ps2 = 1'b1;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
            end
            if (k == glitch_edge) begin
                repeat (8) @(negedge clk);
                dev_c = 1'b1;
                repeat (5) @(negedge clk);
                dev_c = 1'b0;
            end
        end
        if (ack) begin
            repeat (5) @(negedge clk);
            dev_d = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
    } vec_t;

    vec_t par_vecs[3] = '{'{8'hED, 1'b1}, '{8'h00, 1'b1}, '{8'hFF, 1'b1}};

    initial begin
        logic [10:0] bits;
        int          d0, e0, len;

        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int          d0, e0, len, dly;

        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_idle", 32'(bus.tx_idle), 32'd1);
        check("rst_done", 32'(bus.tx_done_tick), 32'd0);
        check("rst_err", 32'(bus.tx_err_tick), 32'd0);
        check("rst_ps2c", 32'(ps2c), 32'd1);
        check("rst_ps2d", 32'(ps2d), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Send 0xF4 with acknowledge; a request in the done-tick cycle is ignored.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        check("f4_busy", 32'(bus.tx_idle), 32'd0);
        device_frame(1'b1, 11, 0, 0, "f4", bits);
        check("f4_frame", 32'(bits), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
        len = 0;
        while (bus.tx_done_tick !== 1'b1 && len < 50) begin
            len++;
            @(negedge clk);
        end
        check("f4_done_seen", 32'(bus.tx_done_tick), 32'd1);
        send(8'h55);
        check("f4_idle_after_tick", 32'(bus.tx_idle), 32'd1);
        repeat (5) @(negedge clk);
        check("wr_on_tick_ignored_c", 32'(ps2c), 32'd1);
        check("wr_on_tick_ignored_idle", 32'(bus.tx_idle), 32'd1);
        check("f4_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("f4_no_err", 32'(err_cnt - e0), 32'd0);

        // Parity vectors.
        foreach (par_vecs[i]) begin
            d0 = done_cnt;
            send(par_vecs[i].d);
            device_frame(1'b1, 11, 0, 0, "par", bits);
            repeat (20) @(negedge clk);
            check("par_frame", 32'(bits), 32'({1'b1, par_vecs[i].par, par_vecs[i].d, 1'b0}));
            check("par_done", 32'(done_cnt - d0), 32'd1);
        end

        // No acknowledge (0x3C, parity 1).
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        device_frame(1'b0, 11, 0, 0, "nak", bits);
        repeat (20) @(negedge clk);
        check("nak_frame", 32'(bits), 32'({1'b1, 1'b1, 8'h3C, 1'b0}));
        check("nak_err", 32'(err_cnt - e0), 32'd1);
        check("nak_no_done", 32'(done_cnt - d0), 32'd0);
        check("nak_idle", 32'(bus.tx_idle), 32'd1);

        // Request while busy (0x12, parity 1) with 0xAA poked during DATA.
        d0 = done_cnt;
        send(8'h12);
        device_frame(1'b1, 11, 3, 0, "busy", bits);
        repeat (20) @(negedge clk);
        check("busy_frame", 32'(bits), 32'({1'b1, 1'b1, 8'h12, 1'b0}));
        check("busy_done", 32'(done_cnt - d0), 32'd1);
        check("busy_no_restart", 32'(ps2c), 32'd1);

        // Glitch on ps2c during DATA (0xC3, parity 1).
        d0 = done_cnt;
        send(8'hC3);
        device_frame(1'b1, 11, 0, 4, "glitch", bits);
        repeat (20) @(negedge clk);
        check("glitch_frame", 32'(bits), 32'({1'b1, 1'b1, 8'hC3, 1'b0}));
        check("glitch_done", 32'(done_cnt - d0), 32'd1);

        // Timeout: device stops after edge 4.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00);
        device_frame(1'b0, 4, 0, 0, "tmo", bits);
        len = 0;
        while (err_cnt == e0 && len < 3 * TIMEOUT) begin
            len++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        dly = err_cyc - last_fall_cyc;
        check("tmo_delay", 32'(dly >= TIMEOUT + 10 && dly <= TIMEOUT + 12), 32'd1);
        check("tmo_ps2c", 32'(ps2c), 32'd1);
        check("tmo_ps2d", 32'(ps2d), 32'd1);
        check("tmo_idle", 32'(bus.tx_idle), 32'd1);
        check("tmo_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset mid-DATA while the host pulls ps2d low for a 0 bit.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00);
        device_frame(1'b0, 3, 0, 0, "rst", bits);
        check("rst_pre_d_low", 32'(ps2d), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_ps2d", 32'(ps2d), 32'd1);
        check("rst_mid_ps2c", 32'(ps2c), 32'd1);
        check("rst_mid_idle", 32'(bus.tx_idle), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_no_ticks", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        check("tick_width", 32'(wide_cnt), 32'd0);
        check("tick_idle_relation", 32'(idle_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
